// File: rtl/sgd_update_if.sv
// Bus bundle for the SGD update stage.
// The master drives the request, learning rate, parameters and gradients.
// The slave returns the updated parameters together with busy/done status.
interface sgd_update_if #(
    parameter int M  = 5,
    parameter int N  = 3,
    parameter int DW = 16
);
    logic                 start;
    logic signed [DW-1:0] lr;
    logic signed [DW-1:0] W     [0:M-1][0:N-1];
    logic signed [DW-1:0] b     [0:M-1][0:0];
    logic signed [DW-1:0] dw    [0:M-1][0:N-1];
    logic signed [DW-1:0] db    [0:M-1][0:0];
    logic signed [DW-1:0] W_new [0:M-1][0:N-1];
    logic signed [DW-1:0] b_new [0:M-1][0:0];
    logic                 busy;
    logic                 done;

    modport master (
        output start, lr, W, b, dw, db,
        input  W_new, b_new, busy, done
    );

    modport slave (
        input  start, lr, W, b, dw, db,
        output W_new, b_new, busy, done
    );
endinterface

// File: rtl/sgd_update.sv
// Gradient-descent update stage: W' = W - lr*dw, b' = b - lr*db.
// One element is processed per clock through a single shared multiplier.
// Operands are snapshotted in LOAD so later input changes cannot disturb a run.
// Each result is shifted right arithmetically by FRAC (floor) and saturated to DW bits.
module sgd_update #(
    parameter int M    = 5,
    parameter int N    = 3,
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input logic       clk,
    input logic       reset,
    sgd_update_if.slave bus
);
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * DW;
    localparam int XW = 2 * DW + 1;

    // Saturation bounds expressed in the widened difference domain
    localparam logic signed [XW-1:0] SAT_MAX = {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = {{(XW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_UPD_W = 3'd2,
        S_UPD_B = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    logic [RW-1:0]        r_row;
    logic [CW-1:0]        r_col;
    logic                 r_busy;
    logic                 r_done;
    logic signed [DW-1:0] r_lr;
    logic signed [DW-1:0] r_w     [0:M-1][0:N-1];
    logic signed [DW-1:0] r_b     [0:M-1][0:0];
    logic signed [DW-1:0] r_dw    [0:M-1][0:N-1];
    logic signed [DW-1:0] r_db    [0:M-1][0:0];
    logic signed [DW-1:0] r_w_new [0:M-1][0:N-1];
    logic signed [DW-1:0] r_b_new [0:M-1][0:0];

    logic signed [DW-1:0] w_g;
    logic signed [DW-1:0] w_base;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shift;
    logic signed [XW-1:0] w_diff;
    logic signed [DW-1:0] w_res;

    // Clamp a widened difference into the signed DW-bit range
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [XW-1:0] v);
        logic signed [DW-1:0] res;
        if (v > SAT_MAX) begin
            res = SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            res = SAT_MIN[DW-1:0];
        end else begin
            res = v[DW-1:0];
        end
        return res;
    endfunction

    // Operand mux plus the single shared multiply/shift/subtract/saturate datapath
    always_comb begin
        w_g    = '0;
        w_base = '0;
        if (r_state == S_UPD_B) begin
            w_g    = r_db[r_row][0];
            w_base = r_b[r_row][0];
        end else begin
            w_g    = r_dw[r_row][r_col];
            w_base = r_w[r_row][r_col];
        end
        w_prod  = PW'(r_lr) * PW'(w_g);
        w_shift = w_prod >>> FRAC;
        w_diff  = XW'(w_base) - XW'(w_shift);
        w_res   = sat_dw(w_diff);
    end

    // Control FSM, operand snapshot and in-place result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lr    <= '0;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_w[i][j]     <= '0;
                    r_dw[i][j]    <= '0;
                    r_w_new[i][j] <= '0;
                end
                r_b[i][0]     <= '0;
                r_db[i][0]    <= '0;
                r_b_new[i][0] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_lr    <= bus.lr;
                    r_w     <= bus.W;
                    r_b     <= bus.b;
                    r_dw    <= bus.dw;
                    r_db    <= bus.db;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_state <= S_UPD_W;
                end
                S_UPD_W: begin
                    r_w_new[r_row][r_col] <= w_res;
                    if (r_col == CW'(N - 1)) begin
                        r_col <= '0;
                        if (r_row == RW'(M - 1)) begin
                            r_row   <= '0;
                            r_state <= S_UPD_B;
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
                S_UPD_B: begin
                    r_b_new[r_row][0] <= w_res;
                    if (r_row == RW'(M - 1)) begin
                        r_row   <= '0;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.W_new = r_w_new;
    assign bus.b_new = r_b_new;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_sgd_update.sv
// Self-checking bench for sgd_update: a 2x2 instance for directed vectors and
// multi-cycle corner cases, and a 5x3 instance checked against a reference model.
module tb_sgd_update;
    logic clk;
    logic reset_a;
    logic reset_b;
    int   checks;
    int   errors;

    sgd_update_if #(.M(2), .N(2), .DW(16)) bus_a ();
    sgd_update_if #(.M(5), .N(3), .DW(16)) bus_b ();

    sgd_update #(.M(2), .N(2), .DW(16), .FRAC(8)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    sgd_update #(.M(5), .N(3), .DW(16), .FRAC(8)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] lr;
        logic [15:0] w;
        logic [15:0] dw;
        logic [15:0] b;
        logic [15:0] db;
        logic [15:0] exp_w;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [0:6];

    logic [15:0] tw  [0:4][0:2];
    logic [15:0] tdw [0:4][0:2];
    logic [15:0] tb_ [0:4];
    logic [15:0] tdb [0:4];

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_upd(input logic [15:0] w, input logic [15:0] g,
                                            input logic [15:0] lr);
        int p;
        int s;
        int r;
        p = int'($signed(lr)) * int'($signed(g));
        s = p >>> 8;
        r = int'($signed(w)) - s;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic set_a(input logic [15:0] lr, input logic [15:0] w, input logic [15:0] dw,
                         input logic [15:0] b, input logic [15:0] db);
        bus_a.lr = lr;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                bus_a.W[i][j]  = w;
                bus_a.dw[i][j] = dw;
            end
            bus_a.b[i][0]  = b;
            bus_a.db[i][0] = db;
        end
    endtask

    // Pulse start on dut_a (called at a negedge) and count negedges until done
    task automatic start_a_wait(output int lat);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        lat = 1;
        while (bus_a.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_a_all(input string tag, input logic [15:0] ew, input logic [15:0] eb);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                check16($sformatf("%s W_new[%0d][%0d]", tag, i, j), bus_a.W_new[i][j], ew);
            end
            check16($sformatf("%s b_new[%0d]", tag, i), bus_a.b_new[i][0], eb);
        end
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int dcount;
        int first_d;
        int second_d;

        checks = 0;
        errors = 0;

        vecs[0] = '{16'h0080, 16'h0100, 16'h0100, 16'h0200, 16'h0100, 16'h0080, 16'h0180};
        vecs[1] = '{16'h0100, 16'h8001, 16'h7FFF, 16'h8001, 16'h7FFF, 16'h8000, 16'h8000};
        vecs[2] = '{16'h0100, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
        vecs[3] = '{16'h0080, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
        vecs[4] = '{16'h0080, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h0001};
        vecs[5] = '{16'h0000, 16'h1234, 16'h7FFF, 16'hF00D, 16'h8000, 16'h1234, 16'hF00D};
        vecs[6] = '{16'hFF00, 16'h0100, 16'h0200, 16'h0000, 16'hFF80, 16'h0300, 16'hFF80};

        reset_a     = 1'b0;
        reset_b     = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        set_a(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        bus_b.lr = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 3; j++) begin
                bus_b.W[i][j]  = 16'h0000;
                bus_b.dw[i][j] = 16'h0000;
            end
            bus_b.b[i][0]  = 16'h0000;
            bus_b.db[i][0] = 16'h0000;
        end

        // Reset state
        repeat (3) @(negedge clk);
        reset_a = 1'b1;
        reset_b = 1'b1;
        @(negedge clk);
        check16("reset busy", {15'd0, bus_a.busy}, 16'h0000);
        check16("reset done", {15'd0, bus_a.done}, 16'h0000);
        check_a_all("reset", 16'h0000, 16'h0000);
        check16("reset b busy", {15'd0, bus_b.busy}, 16'h0000);

        // Directed vector table
        for (int k = 0; k < 7; k++) begin
            set_a(vecs[k].lr, vecs[k].w, vecs[k].dw, vecs[k].b, vecs[k].db);
            start_a_wait(lat);
            check_int($sformatf("v%0d latency", k), lat, 8);
            check16($sformatf("v%0d busy at done", k), {15'd0, bus_a.busy}, 16'h0000);
            check_a_all($sformatf("v%0d", k), vecs[k].exp_w, vecs[k].exp_b);
            @(negedge clk);
            check16($sformatf("v%0d done one cycle", k), {15'd0, bus_a.done}, 16'h0000);
        end

        // Start held high for 20 cycles; inputs change after LOAD
        set_a(vecs[0].lr, vecs[0].w, vecs[0].dw, vecs[0].b, vecs[0].db);
        bus_a.start = 1'b1;
        dcount   = 0;
        first_d  = 0;
        second_d = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 20) bus_a.start = 1'b0;
            if (c == 2) set_a(16'h0100, 16'h7000, 16'h0000, 16'h0500, 16'h0000);
            if (bus_a.done === 1'b1) begin
                dcount++;
                if (dcount == 1) begin
                    first_d = c;
                    check_a_all("held snapshot", 16'h0080, 16'h0180);
                end else if (dcount == 2) begin
                    second_d = c;
                end
            end
        end
        check_int("held done count", dcount, 2);
        check_int("held done spacing", second_d - first_d, 9);
        lat = 0;
        while (bus_a.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check16("held third run W_new", bus_a.W_new[1][1], 16'h7000);
        check16("held third run b_new", bus_a.b_new[1][0], 16'h0500);
        @(negedge clk);

        // Reset mid-UPD_W aborts and clears everything
        set_a(vecs[0].lr, vecs[0].w, vecs[0].dw, vecs[0].b, vecs[0].db);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check16("pre-abort busy", {15'd0, bus_a.busy}, 16'h0001);
        #2;
        reset_a = 1'b0;
        #1;
        check16("abort busy", {15'd0, bus_a.busy}, 16'h0000);
        check16("abort done", {15'd0, bus_a.done}, 16'h0000);
        check_a_all("abort", 16'h0000, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset_a  = 1'b1;
        dcount   = 0;
        busy_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) dcount++;
            if (bus_a.busy === 1'b1) busy_cnt++;
        end
        check_int("post-abort done pulses", dcount, 0);
        check_int("post-abort busy cycles", busy_cnt, 0);

        // 5x3 instance against the reference model
        for (int it = 0; it < 3; it++) begin
            if (it == 0) bus_b.lr = 16'($urandom_range(0, 511));
            else if (it == 1) bus_b.lr = 16'($urandom);
            else bus_b.lr = 16'(16'hFF00 + 16'($urandom_range(0, 255)));
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 3; j++) begin
                    tw[i][j]  = 16'($urandom);
                    tdw[i][j] = 16'($urandom);
                    bus_b.W[i][j]  = tw[i][j];
                    bus_b.dw[i][j] = tdw[i][j];
                end
                tb_[i] = 16'($urandom);
                tdb[i] = 16'($urandom);
                bus_b.b[i][0]  = tb_[i];
                bus_b.db[i][0] = tdb[i];
            end
            bus_b.start = 1'b1;
            @(negedge clk);
            bus_b.start = 1'b0;
            lat      = 1;
            busy_cnt = 0;
            while (bus_b.done !== 1'b1 && lat < 80) begin
                if (bus_b.busy === 1'b1) busy_cnt++;
                @(negedge clk);
                lat++;
            end
            check_int($sformatf("r%0d latency", it), lat, 22);
            check_int($sformatf("r%0d busy cycles", it), busy_cnt, 21);
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 3; j++) begin
                    check16($sformatf("r%0d W_new[%0d][%0d]", it, i, j), bus_b.W_new[i][j],
                            ref_upd(tw[i][j], tdw[i][j], bus_b.lr));
                end
                check16($sformatf("r%0d b_new[%0d]", it, i), bus_b.b_new[i][0],
                        ref_upd(tb_[i], tdb[i], bus_b.lr));
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
